shift_counter_n: RTL and testbench
==================================

Name: shift_counter_n

Overview:
- Parametrised shift-register counter: WIDTH-bit Johnson (twisted-ring) or ring counter, selected at run time.
- Adds direction control, enable, parallel load, illegal-state self-correction, a decoded step index and a wrap pulse.
- Drop-in generalisation of the fixed 4-bit Johnson counters; used as a sequence/phase generator in the counter library.

Parameters:
- WIDTH, 4, number of state bits; legal range 2..32.
- IDXW, $clog2(2*WIDTH), width of the idx output (derived; do not override).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  step enable; no step when 0.
- mode  input  1  0 = Johnson (period 2*WIDTH), 1 = ring (period WIDTH).
- dir  input  1  0 = right shift / count up, 1 = left shift / count down.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  WIDTH  value loaded when load=1.
- out  output  WIDTH  counter state (registered).
- idx  output  IDXW  step index of out in the current mode; 0 when illegal.
- illegal  output  1  combinational: out is not a legal state for mode.
- wrap  output  1  registered one-cycle pulse: the last step landed on index 0.
- err  output  1  registered one-cycle pulse: a self-correction occurred.

Behaviour:
- Reset (rst=0, async): out=0, wrap=0, err=0. Release is synchronous to clk.
- Johnson step, dir=0: out[W-1] <= ~out[0], out[i] <= out[i+1].
- Johnson step, dir=1: out[0] <= ~out[W-1], out[i] <= out[i-1].
- Ring step: the same shifts without inversion.
- Johnson legal states: at most one 0/1 transition across bits W-1..0 (2*W states).
  - idx=0: all zeros.
  - idx=k for k=1..W: top k bits are 1, rest 0.
  - idx=W+k for k=1..W-1: top k bits are 0, rest 1.
- Ring legal states: exactly one bit set. Hot bit p gives idx=(W-p) mod W.
- Ring exception: the all-zero state (reset value) is seed-pending. illegal=0, idx=0. The first enabled step loads 0..01 with no err.
- dir=0 increments idx and dir=1 decrements it, modulo the period.
- Priority per cycle:
  1. load=1: out <= load_val, regardless of en. No wrap, no err. An illegal value is accepted as-is.
  2. Else en=1 and illegal: out <= seed (Johnson 0, ring 0..01), err=1, wrap=0.
  3. Else en=1: one step. wrap=1 if the new idx is 0.
  4. Else: hold.
- wrap and err are 0 in every cycle not listed above.
- Mode change: takes effect on the next edge. A state legal in the old mode but illegal in the new one is corrected on the next enabled step. dir may change any cycle.
- No step latency beyond the single register. idx and illegal follow out combinationally.
- Reset mid-sequence: immediate clear of out, wrap and err. No pulse is generated.

Decomposition:
- Package shift_counter_pkg:
  - MODE_JOHNSON=1'b0, MODE_RING=1'b1, DIR_UP=1'b0, DIR_DOWN=1'b1.
  - Functions johnson_legal, ring_legal, johnson_idx, ring_idx, parametrised on WIDTH.
- Sub-module shift_cnt_decode: purely combinational. Takes out and mode; produces illegal and idx. Reused by the bench scoreboard.
- Top block holds the state register, next-state mux and the wrap/err flops.

Test Plan:
- WIDTH=4, reset, mode=0, dir=0, en=1 for 9 clocks -> out 1000,1100,1110,1111,0111,0011,0001,0000,1000; idx 1..7,0,1; wrap only after the 8th step.
- WIDTH=4, from 0000, mode=0, dir=1 for 3 clocks -> 0001,0011,0111; idx 7,6,5; no wrap.
- WIDTH=4, mode=1 from reset, 5 steps with dir=0 -> 0001 (err=0), 1000,0100,0010,0001; idx 0,1,2,3,0; wrap after step 5.
- load=1, load_val=1010, mode=0 -> out=1010, illegal=1, idx=0. Next cycle en=1 -> out=0000, err=1 for exactly one cycle.
- load=1 together with en=1 and illegal state -> load wins: out=load_val, err=0.
- Johnson state 1100 (mode=0) switched to mode=1 -> illegal=1 with en=0 and out held. First en cycle -> out=0001, err=1.
- Assert rst=0 mid-cycle between edges -> out=0000 immediately, wrap=err=0.
- Sweep WIDTH=2 and WIDTH=7 full periods in both directions; scoreboard checks idx against shift_cnt_decode.

Source files
------------

// File: rtl/shift_counter_pkg.sv
// shift_counter_pkg: mode/direction encodings and state legality/index helpers for shift counters.
package shift_counter_pkg;

    localparam logic MODE_JOHNSON = 1'b0;
    localparam logic MODE_RING    = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam int   MAXW         = 32;

    function automatic logic johnson_legal(input logic [MAXW-1:0] v, input int w);
        int t;
        t = 0;
        for (int i = 1; i < MAXW; i++)
            if (i < w && v[i] != v[i-1]) t++;
        return t <= 1;
    endfunction

    // All-zero counts as legal: it is the seed-pending reset state.
    function automatic logic ring_legal(input logic [MAXW-1:0] v, input int w);
        int c;
        c = 0;
        for (int i = 0; i < MAXW; i++)
            if (i < w && v[i]) c++;
        return c <= 1;
    endfunction

    function automatic logic [5:0] johnson_idx(input logic [MAXW-1:0] v, input int w);
        int ones;
        ones = 0;
        for (int i = 0; i < MAXW; i++)
            if (i < w && v[i]) ones++;
        return 6'(v[w-1] ? ones : (ones == 0 ? 0 : 2 * w - ones));
    endfunction

    function automatic logic [5:0] ring_idx(input logic [MAXW-1:0] v, input int w);
        int r;
        r = 0;
        for (int i = 1; i < MAXW; i++)
            if (i < w && v[i]) r = w - i;
        return 6'(r);
    endfunction

endpackage

// File: rtl/shift_cnt_decode.sv
// shift_cnt_decode: combinational legality check and step index of a shift-counter state.
module shift_cnt_decode
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] out,
    input  logic             mode,
    output logic             illegal,
    output logic [IDXW-1:0]  idx
);

    logic [MAXW-1:0] v;
    logic            legal;

    assign v       = MAXW'(out);
    assign legal   = mode == MODE_RING ? ring_legal(v, WIDTH) : johnson_legal(v, WIDTH);
    assign illegal = ~legal;
    assign idx     = legal ? IDXW'(mode == MODE_RING ? ring_idx(v, WIDTH) : johnson_idx(v, WIDTH)) : '0;

endmodule

// File: rtl/shift_counter_n.sv
// shift_counter_n: run-time selectable Johnson/ring counter with direction, load,
// illegal-state self-correction, decoded index and wrap/err pulses.
module shift_counter_n
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [IDXW-1:0]  idx,
    output logic             illegal,
    output logic             wrap,
    output logic             err
);

    logic [WIDTH-1:0] step, nxt;
    logic             fb_r, fb_l, nxt_wrap, nxt_err;

    shift_cnt_decode #(.WIDTH(WIDTH), .IDXW(IDXW)) u_dec (
        .out     (out),
        .mode    (mode),
        .illegal (illegal),
        .idx     (idx)
    );

    assign fb_r = mode == MODE_RING ? out[0] : ~out[0];
    assign fb_l = mode == MODE_RING ? out[WIDTH-1] : ~out[WIDTH-1];
    assign step = dir == DIR_UP ? {fb_r, out[WIDTH-1:1]} : {out[WIDTH-2:0], fb_l};

    // Ring all-zero is seeded quietly; a stepped-into index 0 raises wrap.
    always_comb begin
        nxt      = out;
        nxt_wrap = 1'b0;
        nxt_err  = 1'b0;
        if (load)
            nxt = load_val;
        else if (en && illegal) begin
            nxt     = mode == MODE_JOHNSON ? '0 : WIDTH'(1);
            nxt_err = 1'b1;
        end
        else if (en && mode == MODE_RING && out == '0)
            nxt = WIDTH'(1);
        else if (en) begin
            nxt      = step;
            nxt_wrap = mode == MODE_RING ? step == WIDTH'(1) : step == '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out  <= '0;
            wrap <= 1'b0;
            err  <= 1'b0;
        end
        else begin
            out  <= nxt;
            wrap <= nxt_wrap;
            err  <= nxt_err;
        end
    end

endmodule

// File: tb/tb_shift_counter_n.sv
// tb_shift_counter_n: randomized and directed checks of shift_counter_n at WIDTH 4, 2 and 7
// against an index-based reference model.
module tb_shift_counter_n;

    localparam int W [3] = '{4, 2, 7};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en_a [3], mode_a [3], dir_a [3], load_a [3];
    logic [31:0] lv_a [3];
    logic [31:0] out_a [3];
    logic [5:0]  idx_a [3];
    logic        wrap_a [3], err_a [3], ill_a [3];
    logic [3:0]  o0, i2;
    logic [1:0]  o1, i1;
    logic [6:0]  o2;
    logic [2:0]  i0;
    logic [31:0] mv [3];
    logic        mw [3], me [3];
    logic        sb_ill;
    logic [3:0]  sb_idx;
    int          errs = 0;
    int          chk = 0;

    always #5 clk = ~clk;

    shift_counter_n #(.WIDTH(4)) d0 (
        .clk(clk), .rst(rst), .en(en_a[0]), .mode(mode_a[0]), .dir(dir_a[0]), .load(load_a[0]),
        .load_val(lv_a[0][3:0]), .out(o0), .idx(i0), .illegal(ill_a[0]), .wrap(wrap_a[0]), .err(err_a[0])
    );
    shift_counter_n #(.WIDTH(2)) d1 (
        .clk(clk), .rst(rst), .en(en_a[1]), .mode(mode_a[1]), .dir(dir_a[1]), .load(load_a[1]),
        .load_val(lv_a[1][1:0]), .out(o1), .idx(i1), .illegal(ill_a[1]), .wrap(wrap_a[1]), .err(err_a[1])
    );
    shift_counter_n #(.WIDTH(7)) d2 (
        .clk(clk), .rst(rst), .en(en_a[2]), .mode(mode_a[2]), .dir(dir_a[2]), .load(load_a[2]),
        .load_val(lv_a[2][6:0]), .out(o2), .idx(i2), .illegal(ill_a[2]), .wrap(wrap_a[2]), .err(err_a[2])
    );
    shift_cnt_decode #(.WIDTH(7)) sb (.out(mv[2][6:0]), .mode(mode_a[2]), .illegal(sb_ill), .idx(sb_idx));

    assign out_a[0] = 32'(o0);
    assign out_a[1] = 32'(o1);
    assign out_a[2] = 32'(o2);
    assign idx_a[0] = 6'(i0);
    assign idx_a[1] = 6'(i1);
    assign idx_a[2] = 6'(i2);

    // State sitting at index k: Johnson fills ones from the top, then drains them; ring has one hot bit.
    function automatic logic [31:0] mstate(int k, logic m, int w);
        if (m) return 32'(1) << ((w - k) % w);
        if (k <= w) return ((32'(1) << k) - 1) << (w - k);
        return (32'(1) << (2 * w - k)) - 1;
    endfunction

    function automatic int midx(logic [31:0] v, logic m, int w);
        if (m && v == 0) return 0;
        for (int k = 0; k < (m ? w : 2 * w); k++)
            if (mstate(k, m, w) == v) return k;
        return -1;
    endfunction

    function automatic logic [40:0] expb(int n);
        int id;
        id = midx(mv[n], mode_a[n], W[n]);
        return {mv[n], id < 0 ? 6'd0 : 6'(id), mw[n], me[n], id < 0};
    endfunction

    function automatic logic [40:0] actb(int n);
        return {out_a[n], idx_a[n], wrap_a[n], err_a[n], ill_a[n]};
    endfunction

    task automatic model_step();
        for (int n = 0; n < 3; n++) begin
            int w;
            int p;
            int id;
            w = W[n];
            p = mode_a[n] ? w : 2 * w;
            id = midx(mv[n], mode_a[n], w);
            mw[n] = 1'b0;
            me[n] = 1'b0;
            if (load_a[n])
                mv[n] = lv_a[n] & ((32'(1) << w) - 1);
            else if (en_a[n]) begin
                if (mode_a[n] && mv[n] == 0)
                    mv[n] = 1;
                else if (id < 0) begin
                    mv[n] = mode_a[n] ? 1 : 0;
                    me[n] = 1'b1;
                end
                else begin
                    id = dir_a[n] ? (id + p - 1) % p : (id + 1) % p;
                    mv[n] = mstate(id, mode_a[n], w);
                    mw[n] = id == 0;
                end
            end
        end
    endtask

    task automatic tick(int n, logic e, logic m, logic d, logic l, logic [31:0] lv);
        en_a[n] = e;
        mode_a[n] = m;
        dir_a[n] = d;
        load_a[n] = l;
        lv_a[n] = lv;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            mv[n] = 0;
            mw[n] = 1'b0;
            me[n] = 1'b0;
            en_a[n] = 1'b0;
            load_a[n] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) begin
            chk++;
            if (actb(n) !== expb(n)) begin
                errs++;
                $display("FAIL reset n=%0d got=%h exp=%h", n, actb(n), expb(n));
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_johnson_up();
        logic [3:0] tbl [9] = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0, 4'h8};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick(0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
            chk++;
            if (actb(0) !== expb(0)) begin
                errs++;
                $display("FAIL johnson_up step=%0d got=%h exp=%h", i, actb(0), expb(0));
            end
            chk++;
            if (o0 !== tbl[i]) begin
                errs++;
                $display("FAIL johnson_up_tbl step=%0d got=%h exp=%h", i, o0, tbl[i]);
            end
        end
    endtask

    task automatic test_johnson_down();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
            chk++;
            if (actb(0) !== expb(0)) begin
                errs++;
                $display("FAIL johnson_down step=%0d got=%h exp=%h", i, actb(0), expb(0));
            end
        end
    endtask

    task automatic test_ring_seed();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
            chk++;
            if (actb(0) !== expb(0)) begin
                errs++;
                $display("FAIL ring_seed step=%0d got=%h exp=%h", i, actb(0), expb(0));
            end
        end
    endtask

    task automatic test_load_illegal();
        tick(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA);
        chk++;
        if (actb(0) !== expb(0)) begin
            errs++;
            $display("FAIL load_illegal got=%h exp=%h", actb(0), expb(0));
        end
        for (int i = 0; i < 2; i++) begin
            tick(0, i == 0, 1'b0, 1'b0, 1'b0, 0);
            chk++;
            if (actb(0) !== expb(0)) begin
                errs++;
                $display("FAIL correct_pulse cyc=%0d got=%h exp=%h", i, actb(0), expb(0));
            end
        end
    endtask

    task automatic test_load_priority();
        tick(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA);
        tick(0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h6);
        chk++;
        if (actb(0) !== expb(0) || o0 !== 4'h6 || err_a[0] !== 1'b0) begin
            errs++;
            $display("FAIL load_priority got=%h exp=%h", actb(0), expb(0));
        end
    endtask

    task automatic test_mode_switch();
        tick(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC);
        for (int i = 0; i < 3; i++) begin
            tick(0, i == 2, 1'b1, 1'b0, 1'b0, 0);
            chk++;
            if (actb(0) !== expb(0)) begin
                errs++;
                $display("FAIL mode_switch cyc=%0d got=%h exp=%h", i, actb(0), expb(0));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) tick(0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        #3;
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            mv[n] = 0;
            mw[n] = 1'b0;
            me[n] = 1'b0;
        end
        #1;
        for (int n = 0; n < 3; n++) begin
            chk++;
            if (actb(n) !== expb(n)) begin
                errs++;
                $display("FAIL async_reset n=%0d got=%h exp=%h", n, actb(n), expb(n));
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_sweep(int n);
        for (int m = 0; m < 2; m++)
            for (int d = 0; d < 2; d++) begin
                int p;
                p = m ? W[n] : 2 * W[n];
                do_reset();
                for (int c = 0; c < 2 * p + 2; c++) begin
                    int id;
                    tick(n, c < 2 || ($urandom % 4) != 0, m[0], d[0], 1'b0, 0);
                    chk++;
                    if (actb(n) !== expb(n)) begin
                        errs++;
                        $display("FAIL sweep n=%0d m=%0d d=%0d c=%0d got=%h exp=%h", n, m, d, c, actb(n), expb(n));
                    end
                    id = midx(mv[2], mode_a[2], 7);
                    if (n == 2) begin
                        chk++;
                        if ({sb_ill, sb_idx} !== {id < 0, id < 0 ? 4'd0 : 4'(id)}) begin
                            errs++;
                            $display("FAIL scoreboard_decode c=%0d got=%h exp=%0d", c, {sb_ill, sb_idx}, id);
                        end
                    end
                end
            end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick(0, ($urandom % 4) != 0, ($urandom % 8) == 0 ? ~mode_a[0] : mode_a[0],
                 1'($urandom % 2), ($urandom % 10) == 0, $urandom);
            chk++;
            if (actb(0) !== expb(0)) begin
                errs++;
                $display("FAIL random c=%0d got=%h exp=%h", c, actb(0), expb(0));
            end
        end
    endtask

    initial begin
        for (int n = 0; n < 3; n++) begin
            en_a[n] = 1'b0;
            mode_a[n] = 1'b0;
            dir_a[n] = 1'b0;
            load_a[n] = 1'b0;
            lv_a[n] = 0;
            mv[n] = 0;
            mw[n] = 1'b0;
            me[n] = 1'b0;
        end
        test_reset();
        test_johnson_up();
        test_johnson_down();
        test_ring_seed();
        test_load_illegal();
        test_load_priority();
        test_mode_switch();
        test_async_reset();
        test_sweep(1);
        test_sweep(2);
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, chk);
        $finish;
    end

endmodule
